gcd_controller: RTL and testbench
=================================

# gcd_controller

Control FSM for the 16-bit subtractive GCD datapath. It drives the datapath's load enables and mux selects, and it consumes the datapath's lt/gt/eq comparator flags. It runs the sequence load A, load B, then repeated compare/subtract until A equals B. It reports completion, a subtraction count, and a timeout error for degenerate operands (a zero operand with a nonzero one never converges).

## Interface
Parameters:
- CNT_W, 16, width of the iteration counter.
- MAX_ITER, 2**CNT_W-1, maximum number of subtractions before the FSM aborts with err.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new GCD. Sampled only in IDLE.
- lt  in  1  datapath flag, A<B.
- gt  in  1  datapath flag, A>B.
- eq  in  1  datapath flag, A==B.
- lda  out  1  load register A from the bus.
- ldb  out  1  load register B from the bus.
- sel1  out  1  subtractor minuend select: 0=A, 1=B.
- sel2  out  1  subtractor subtrahend select: 0=A, 1=B.
- selin  out  1  bus select: 1=data_in, 0=subtractor output.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the result is in both A and B.
- err  out  1  one-cycle pulse; MAX_ITER was exceeded.
- iter_cnt  out  CNT_W  number of subtractions in the current or last run.

## Operation
- The FSM is Moore. All outputs except iter_cnt decode from the state register only. lt/gt/eq affect only the next state.
- States and outputs. Any output not listed is 0.
  - IDLE: no outputs. On start=1, go to LOAD_A and clear iter_cnt to 0.
  - LOAD_A: lda=1, selin=1. The upstream source holds operand A on data_in during this cycle. Always goes to LOAD_B.
  - LOAD_B: ldb=1, selin=1. The upstream source holds operand B on data_in. Always goes to CMP.
  - CMP: no loads; the flags are valid in this cycle. The first matching rule wins:
    - eq → DONE.
    - iter_cnt==MAX_ITER → ERR.
    - gt → SUB_A.
    - lt → SUB_B.
  - SUB_A: lda=1, sel1=0, sel2=1, selin=0, so A←A−B. iter_cnt+1. Goes to CMP.
  - SUB_B: ldb=1, sel1=1, sel2=0, selin=0, so B←B−A. iter_cnt+1. Goes to CMP.
  - DONE: done=1. Goes to IDLE.
  - ERR: err=1. Goes to IDLE.
- If no flag is set or more than one is set in CMP (an illegal datapath state), go to ERR.
- iter_cnt holds its value in IDLE until the next accepted start. It does not wrap, because the MAX_ITER check fires first.
- start during busy is ignored. start held high through DONE or ERR launches a new run from the following IDLE cycle.
- Operand cases:
  - A=B=0 → DONE, result 0, iter_cnt=0.
  - A=0,B≠0 or A≠0,B=0 → ERR after exactly MAX_ITER subtractions.

## Timing
- Reset: rst_n low asynchronously forces IDLE, iter_cnt=0, and all outputs 0. This holds mid-run too; the datapath registers are left as they are.
- Take edge 0 as the edge that samples start=1. Then:
  - LOAD_A is the state after edge 0.
  - LOAD_B is the state after edge 1.
  - The first CMP is the state after edge 2.
- Each subtraction costs 2 cycles (SUB + CMP).
- Completion timing:
  - done is high in the cycle after edge 3+2N, where N is the number of subtractions.
  - err is high in the cycle after edge 3+2·MAX_ITER.
- The FSM returns to IDLE one edge after done or err. A new start is sampled at the earliest on that IDLE cycle's closing edge.
- busy rises after edge 0 and falls on the edge that enters IDLE.

## Structure
- Package gcd_pkg holds:
  - the state enum typedef gcd_state_t (IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE, ERR);
  - localparam DATA_W=16, shared with the datapath.
- Sub-module gcd_iter_counter: a CNT_W-bit counter with synchronous clear and increment enable, asynchronous active-low reset, and a terminal-compare output against MAX_ITER.
- The top level holds the state register, next-state logic, and output decode.
- The bench instantiates gcd_controller together with the datapath.

## Test plan
- Reset then idle: rst_n low → all outputs 0, iter_cnt=0; start=0 for 10 cycles → busy stays 0.
- A=48, B=18 → the subtract sequence is SUB_A, SUB_A, SUB_B, SUB_A; done after edge 11; iter_cnt=4; A=B=6.
- A=B=7 → no subtractions; done after edge 3; iter_cnt=0.
- MAX_ITER=8, A=5, B=0 → 8 consecutive SUB_A; err after edge 19; done never asserted; iter_cnt=8.
- Mid-run reset: A=1000, B=1, assert rst_n low in the 5th SUB_A → IDLE immediately, outputs 0. Then start with A=9, B=6 → done, result 3, iter_cnt=2.
- start pulsed during busy and start held high through done → the busy-time pulse is ignored; a new run begins with LOAD_A exactly 2 edges after the DONE state is entered.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller and its datapath.
package gcd_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CMP,
        SUB_A,
        SUB_B,
        DONE,
        ERR
    } gcd_state_t;

endpackage

// File: rtl/gcd_controller_if.sv
// Control/status bundle between the GCD controller (master) and its datapath/host side (slave).
interface gcd_controller_if
    import gcd_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             start;
    logic             lt;
    logic             gt;
    logic             eq;
    logic             lda;
    logic             ldb;
    logic             sel1;
    logic             sel2;
    logic             selin;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        input  start, lt, gt, eq,
        output lda, ldb, sel1, sel2, selin, busy, done, err, iter_cnt
    );

    modport slave (
        output start, lt, gt, eq,
        input  lda, ldb, sel1, sel2, selin, busy, done, err, iter_cnt
    );

endinterface

// File: rtl/gcd_iter_counter.sv
// Subtraction counter with synchronous clear, increment enable and a terminal compare against MAX_ITER.
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 2**CNT_W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_max
);

    localparam logic [CNT_W-1:0] LIMIT = MAX_ITER[CNT_W-1:0];

    logic [CNT_W-1:0] r_cnt;

    // No wrap guard needed: the controller aborts before incrementing past LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_max = (r_cnt == LIMIT);

endmodule

// File: rtl/gcd_controller.sv
// Moore control FSM for the 16-bit subtractive GCD datapath: load A, load B, compare/subtract until equal.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int unsigned MAX_ITER = 2**CNT_W - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gcd_controller_if.master        bus_if
);

    gcd_state_t       r_state;
    gcd_state_t       w_next;
    logic             r_lda;
    logic             r_ldb;
    logic             r_sel1;
    logic             r_sel2;
    logic             r_selin;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_clr;
    logic             w_inc;
    logic             w_at_max;
    logic             w_flags_bad;
    logic [CNT_W-1:0] w_cnt;

    assign w_flags_bad = !$onehot({bus_if.lt, bus_if.gt, bus_if.eq});
    assign w_clr       = (r_state == IDLE) && bus_if.start;
    assign w_inc       = (r_state == SUB_A) || (r_state == SUB_B);

    gcd_iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .o_cnt    (w_cnt),
        .o_at_max (w_at_max)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (bus_if.start) w_next = LOAD_A;
            LOAD_A: w_next = LOAD_B;
            LOAD_B: w_next = CMP;
            CMP: begin
                if (w_flags_bad)    w_next = ERR;
                else if (bus_if.eq) w_next = DONE;
                else if (w_at_max)  w_next = ERR;
                else if (bus_if.gt) w_next = SUB_A;
                else                w_next = SUB_B;
            end
            SUB_A:  w_next = CMP;
            SUB_B:  w_next = CMP;
            DONE:   w_next = IDLE;
            ERR:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies always match r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_lda   <= 1'b0;
            r_ldb   <= 1'b0;
            r_sel1  <= 1'b0;
            r_sel2  <= 1'b0;
            r_selin <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lda   <= (w_next == LOAD_A) || (w_next == SUB_A);
            r_ldb   <= (w_next == LOAD_B) || (w_next == SUB_B);
            r_sel1  <= (w_next == SUB_B);
            r_sel2  <= (w_next == SUB_A);
            r_selin <= (w_next == LOAD_A) || (w_next == LOAD_B);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            r_err   <= (w_next == ERR);
        end
    end

    assign bus_if.lda      = r_lda;
    assign bus_if.ldb      = r_ldb;
    assign bus_if.sel1     = r_sel1;
    assign bus_if.sel2     = r_sel2;
    assign bus_if.selin    = r_selin;
    assign bus_if.busy     = r_busy;
    assign bus_if.done     = r_done;
    assign bus_if.err      = r_err;
    assign bus_if.iter_cnt = w_cnt;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench: gcd_controller driving a behavioural GCD datapath, checked against an arithmetic GCD model.
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 8;
    localparam int LIMIT    = 3 + 2*MAX_ITER + 10;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] mux1;
    logic [DATA_W-1:0] mux2;
    logic [DATA_W-1:0] busVal;

    gcd_controller_if #(.CNT_W(CNT_W)) dif ();

    gcd_controller #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: the upstream source presents opA while lda is asserted, opB otherwise.
    assign mux1   = dif.sel1 ? regB : regA;
    assign mux2   = dif.sel2 ? regB : regA;
    assign busVal = dif.selin ? (dif.lda ? opA : opB) : (mux1 - mux2);
    assign dif.lt = (regA < regB);
    assign dif.gt = (regA > regB);
    assign dif.eq = (regA == regB);

    always @(posedge clk) begin
        if (dif.lda) regA <= busVal;
        if (dif.ldb) regB <= busVal;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelGcd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            output bit isErr, output int n,
                            output logic [DATA_W-1:0] g, output logic [31:0] seq);
        n     = 0;
        seq   = '0;
        isErr = 1'b0;
        while (a != b) begin
            if (n == MAX_ITER) begin
                isErr = 1'b1;
                break;
            end
            if (a > b) begin
                a   = a - b;
                seq = {seq[30:0], 1'b1};
            end else begin
                b   = b - a;
                seq = {seq[30:0], 1'b0};
            end
            n++;
        end
        g = a;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        @(negedge clk);
        opA   = a;
        opB   = b;
        dif.start = 1'b1;
        @(posedge clk);
    endtask

    // Entered just after edge 0; ends on the negedge of the IDLE cycle that follows done/err.
    task automatic finishRun(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input int pulseEdge, input bit holdEnd);
        bit                expErr;
        int                expN;
        logic [DATA_W-1:0] expG;
        logic [31:0]       expSeq;
        logic [31:0]       obsSeq;
        int                obsSubs;
        int                endEdge;
        bit                seen;
        logic              sawDone;
        logic              sawErr;

        modelGcd(a, b, expErr, expN, expG, expSeq);
        obsSeq  = '0;
        obsSubs = 0;
        endEdge = -1;
        seen    = 1'b0;
        sawDone = 1'b0;
        sawErr  = 1'b0;
        for (int e = 0; e <= LIMIT && !seen; e++) begin
            @(negedge clk);
            if (e == 0) begin
                dif.start = 1'b0;
                checkOutput({name, "_loada"}, {29'd0, dif.lda, dif.selin, dif.busy}, 32'd7);
            end
            if (pulseEdge > 0 && e == pulseEdge)     dif.start = 1'b1;
            if (pulseEdge > 0 && e == pulseEdge + 1) dif.start = 1'b0;
            if (holdEnd && e == pulseEdge + 3)       dif.start = 1'b1;
            if (dif.lda && !dif.selin) begin
                obsSeq = {obsSeq[30:0], 1'b1};
                obsSubs++;
            end
            if (dif.ldb && !dif.selin) begin
                obsSeq = {obsSeq[30:0], 1'b0};
                obsSubs++;
            end
            if (dif.done || dif.err) begin
                seen    = 1'b1;
                endEdge = e;
                sawDone = dif.done;
                sawErr  = dif.err;
            end else begin
                @(posedge clk);
            end
        end
        checkOutput({name, "_finished"}, {31'd0, seen}, 32'd1);
        checkOutput({name, "_done"}, {31'd0, sawDone}, {31'd0, !expErr});
        checkOutput({name, "_err"}, {31'd0, sawErr}, {31'd0, expErr});
        checkOutput({name, "_edge"}, endEdge, 3 + 2*expN);
        checkOutput({name, "_iter"}, {16'd0, dif.iter_cnt}, expN);
        checkOutput({name, "_nsub"}, obsSubs, expN);
        checkOutput({name, "_seq"}, obsSeq, expSeq);
        if (!expErr) begin
            checkOutput({name, "_regA"}, {16'd0, regA}, {16'd0, expG});
            checkOutput({name, "_regB"}, {16'd0, regB}, {16'd0, expG});
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_idle"}, {29'd0, dif.busy, dif.done, dif.err}, 32'd0);
        checkOutput({name, "_hold"}, {16'd0, dif.iter_cnt}, expN);
    endtask

    initial begin
        int  subs;
        bit  hit;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        opA       = '0;
        opB       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {24'd0, dif.lda, dif.ldb, dif.sel1, dif.sel2, dif.selin, dif.busy, dif.done, dif.err}, 32'd0);
        checkOutput("reset_iter", {16'd0, dif.iter_cnt}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_busy", {31'd0, dif.busy}, 32'd0);
        end

        applyStimulus(16'd48, 16'd18);
        finishRun("g48_18", 16'd48, 16'd18, 0, 1'b0);

        applyStimulus(16'd7, 16'd7);
        finishRun("g7_7", 16'd7, 16'd7, 0, 1'b0);

        applyStimulus(16'd5, 16'd0);
        finishRun("g5_0", 16'd5, 16'd0, 0, 1'b0);

        applyStimulus(16'd0, 16'd0);
        finishRun("g0_0", 16'd0, 16'd0, 0, 1'b0);

        // Abort mid-run on the 5th SUB_A with an asynchronous reset.
        applyStimulus(16'd1000, 16'd1);
        subs = 0;
        hit  = 1'b0;
        for (int e = 0; e < LIMIT && !hit; e++) begin
            @(negedge clk);
            if (e == 0) dif.start = 1'b0;
            if (dif.lda && !dif.selin) subs++;
            if (subs == 5) hit = 1'b1;
            else           @(posedge clk);
        end
        checkOutput("midrun_reach", {31'd0, hit}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_outputs",
                    {24'd0, dif.lda, dif.ldb, dif.sel1, dif.sel2, dif.selin, dif.busy, dif.done, dif.err}, 32'd0);
        checkOutput("midrun_iter", {16'd0, dif.iter_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'd9, 16'd6);
        finishRun("g9_6", 16'd9, 16'd6, 0, 1'b0);

        // Busy-time start pulse is ignored; start held through DONE relaunches two edges later.
        applyStimulus(16'd9, 16'd6);
        finishRun("busy_pulse", 16'd9, 16'd6, 2, 1'b1);
        opA = 16'd48;
        opB = 16'd18;
        @(posedge clk);
        finishRun("relaunch", 16'd48, 16'd18, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [DATA_W-1:0] ra;
            logic [DATA_W-1:0] rb;
            ra = DATA_W'($urandom_range(0, 15));
            rb = DATA_W'($urandom_range(0, 15));
            applyStimulus(ra, rb);
            finishRun($sformatf("rand%0d_%0d_%0d", r, ra, rb), ra, rb, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
